uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Packet-atomic round-robin arbiter sharing the debug UART byte transmitter among several on-chip packet sources: debug signal dumps, ping replies, and CPU console output. Each requester streams bytes with a last flag. The arbiter grants one requester for a whole packet and forwards its bytes through a one-byte output register to the UART TX serializer. Sits between the debug core FSM / MMIO console and the UART TX bit engine.

## Interface
Parameters:
- `REQ_CNT`, default 3: number of requesters, ≥2.
- `TIMEOUT`, default 1023: stall cycles before abort, 1..65535. Used only with `TX_ARB_TIMEOUT_EN`.

Ports:
- `clk` — in, 1: system clock. All logic is on the rising edge.
- `rst` — in, 1: asynchronous, active-high reset.
- `req_valid` — in, `REQ_CNT`: requester i has a byte on its slice.
- `req_data` — in, 8×`REQ_CNT`: byte of requester i at `[8*i +: 8]`.
- `req_last` — in, `REQ_CNT`: byte of requester i is the final byte of its packet.
- `req_ready` — out, `REQ_CNT`: byte of requester i is accepted this cycle.
- `tx_data` — out, 8: byte presented to the serializer.
- `tx_valid` — out, 1: `tx_data` is valid.
- `tx_ready` — in, 1: serializer accepts `tx_data` this cycle.
- `grant` — out, `REQ_CNT`: one-hot current owner, or 0.
- `busy` — out, 1: a packet is in progress or a byte is still held in the output register.
- `abort` — out, 1: one-cycle pulse when a packet is aborted by timeout.

## Operation
- State `IDLE`: no grant.
  - If any `req_valid` bit is set, search indices from `rr_ptr` upward, modulo `REQ_CNT`. The first set bit wins.
  - Next edge: `grant` becomes one-hot of the winner and state goes to `SEND`.
- State `SEND`: byte transfer rules.
  - `req_ready[i]` is combinational: `grant[i] & (~tx_valid | tx_ready)`.
  - A transfer happens when `req_valid[g] & req_ready[g]`. On that edge `tx_data` is loaded with the byte and `tx_valid` is set to 1.
  - When `tx_ready` is high and no new byte is loaded, `tx_valid` clears.
- State `SEND`: end of packet.
  - When a byte with `req_last[g]` set transfers, next edge: state goes to `IDLE`, `grant` goes to 0, and `rr_ptr` becomes (g+1) mod `REQ_CNT`.
- Packets are never interleaved. Other requesters' `req_ready` stays 0 during `SEND`.
- `req_valid` is sampled only in `IDLE`. If a requester drops `req_valid` after being granted, it stays granted, and its stall is handled by timeout or held forever (see Configuration).
- `busy` = (state ≠ `IDLE`) | `tx_valid`.
- `rr_ptr` width is `$clog2(REQ_CNT)` and wraps from `REQ_CNT`−1 to 0.

## Timing
- Reset (asynchronous, effective immediately): `grant`=0, `req_ready`=0, `tx_valid`=0, `tx_data`=8'h00, `busy`=0, `abort`=0, `rr_ptr`=0, timeout counter=0, state=`IDLE`.
  - A byte held in the output register is discarded.
  - A packet in progress is dropped, with no abort pulse.
- Grant latency: a request seen in `IDLE` at edge t gives `grant` valid after edge t+1.
  - `req_ready` can assert in that same cycle.
  - The first byte appears on `tx_valid` after edge t+2.
- Throughput: 1 byte/cycle while `tx_ready`=1.
- Backpressure: while `tx_valid=1 & tx_ready=0`, `tx_data` is held stable and `req_ready`=0.
- Packet gap: a minimum of 1 `IDLE` cycle between packets. The final byte may still be in the output register while the next grant is issued.
- One-byte packet: `req_last` set on the first byte is legal and takes 1 `SEND` cycle when not stalled.

## Configuration
- Macro: `TX_ARB_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter increments each `SEND` cycle in which `req_valid[g]`=0.
  - It clears on any transfer, and in `IDLE`. Stalls caused by `tx_ready` do not count.
  - When the counter equals `TIMEOUT`, next edge: `abort`=1 for one cycle, `grant`=0, state=`IDLE`, `rr_ptr`=(g+1) mod `REQ_CNT`.
  - A byte already in the output register is still delivered.
- Undefined: no counter. A granted requester holds the grant indefinitely, and `abort` is tied to 0.

## Test plan
- Basic packet: after reset, `req_valid`=3'b001 with bytes AA, BB, CC (`last` on CC) and `tx_ready`=1.
  - Required: `grant`=001 one cycle later.
  - Required: `tx_data` shows AA, BB, CC on consecutive cycles.
  - Required: `grant`=000 and `busy`=0 two cycles after CC is accepted.
- Round-robin order: `req_valid`=3'b111 at the same time, each source sending a 2-byte packet (0: 10 11; 1: 20 21; 2: 30 31).
  - Required: output stream 10 11 20 21 30 31 with no interleaving.
- Backpressure: hold `tx_ready`=0 for 10 cycles mid-packet.
  - Required: `tx_valid`=1 and `tx_data` stable throughout, `req_ready`=0, no lost or duplicated byte.
- Fairness: requester 0 re-requests continuously while requester 2 is requesting.
  - Required: after a packet from 0, `rr_ptr`=1; requester 1 is idle, so 2 is granted before 0 again.
- Timeout: with `TX_ARB_TIMEOUT_EN` and `TIMEOUT`=8, requester 1 sends one non-last byte, then sets `req_valid`=0.
  - Required: `abort` pulses 8 stall cycles later and `grant`=000.
  - Without the macro: `grant`=010 still held after 100 cycles.
- Reset mid-packet: assert `rst` asynchronously during `SEND`.
  - Required: all outputs are 0 before the next edge.
  - Required: the next arbitration starts at `rr_ptr`=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter feeding the debug UART TX serializer.
// Grant valid one edge after a request is seen in IDLE; each byte reaches tx_data one edge after its transfer.
// req_ready only to the owner, and only while the output register is empty or being drained.
// Optional stall watchdog enabled by defining TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int REQ_CNT = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REQ_CNT-1:0]   req_valid,
  input  logic [8*REQ_CNT-1:0] req_data,
  input  logic [REQ_CNT-1:0]   req_last,
  output logic [REQ_CNT-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [REQ_CNT-1:0]   grant,
  output logic                 busy,
  output logic                 abort
);

  localparam int PW = $clog2(REQ_CNT);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] rr_ptr;     // first index searched at the next arbitration
  logic [PW-1:0] gidx;       // index of the current owner
  logic [PW-1:0] gidx_inc;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] pos;
  logic          win_found;
  logic          tx_free;
  logic          cur_valid;
  logic          cur_last;
  logic [7:0]    cur_data;
  logic          xfer;
  logic          pkt_end;
  logic          tmo;

  assign cur_valid = req_valid[gidx];
  assign cur_last  = req_last[gidx];
  assign cur_data  = req_data[{gidx, 3'b000} +: 8];
  assign gidx_inc  = (gidx == PW'(REQ_CNT - 1)) ? '0 : gidx + 1'b1;

  // Output register can take a byte when empty or being emptied this cycle.
  assign tx_free   = ~tx_valid | tx_ready;
  assign xfer      = (state == SEND) & cur_valid & tx_free;
  assign pkt_end   = xfer & cur_last;
  assign req_ready = grant & {REQ_CNT{tx_free}};
  assign busy      = (state != IDLE) | tx_valid;

  // Round-robin search from rr_ptr upward; descending loop so the lowest offset wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    pos       = '0;
    for (int k = REQ_CNT - 1; k >= 0; k--) begin
      pos = PW'((int'(rr_ptr) + k) % REQ_CNT);
      if (req_valid[pos]) begin
        win_found = 1'b1;
        win_idx   = pos;
      end
    end
  end

  // One-hot owner, only while a packet is in progress.
  always_comb begin
    grant = '0;
    if (state == SEND) grant[gidx] = 1'b1;
  end

`ifdef TX_ARB_TIMEOUT_EN
  logic [15:0] stall_cnt;

  assign tmo = (state == SEND) & ~xfer & (stall_cnt == 16'(TIMEOUT));

  // Counts owner-starved SEND cycles; serializer backpressure does not count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state != SEND) || xfer || tmo) begin
      stall_cnt <= '0;
    end else if (!cur_valid) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // One-cycle abort pulse on the edge that drops the stalled packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) abort <= 1'b0;
    else     abort <= tmo;
  end
`else
  assign tmo   = 1'b0;
  assign abort = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: grant on any request in IDLE, release on last byte or timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = SEND;
      SEND:    if (pkt_end || tmo) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Owner index capture and round-robin pointer advance past the finished owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gidx   <= '0;
      rr_ptr <= '0;
    end else begin
      if ((state == IDLE) && win_found) gidx <= win_idx;
      if (pkt_end || tmo) rr_ptr <= gidx_inc;
    end
  end

  // One-byte output register towards the serializer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else if (xfer) begin
      tx_data  <= cur_data;
      tx_valid <= 1'b1;
    end else if (tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: basic packet, round-robin, backpressure,
// fairness, stall timeout (with or without TX_ARB_TIMEOUT_EN) and async reset mid-packet.
// Inputs change just after the falling edge; outputs are sampled away from the rising edge.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [2:0]  grant;
  logic        busy;
  logic        abort;

  uart_tx_arbiter #(.REQ_CNT(3), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .grant(grant),
    .busy(busy), .abort(abort)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Source models: byte list per requester, valid while bytes remain.
  logic [7:0] s_byte [3][8];
  logic       s_last [3][8];
  int         s_len  [3];
  int         s_pos  [3];

  logic [7:0] out_q[$];
  logic [2:0] grant_q[$];
  logic [2:0] last_grant;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      if (s_pos[i] < s_len[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = s_byte[i][s_pos[i]];
        req_last[i]        = s_last[i][s_pos[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic load(input int i, input int n, input logic [63:0] bytes, input logic [7:0] lmask);
    for (int k = 0; k < n; k++) begin
      s_byte[i][k] = bytes[8*k +: 8];
      s_last[i][k] = lmask[k];
    end
    s_len[i] = n;
    s_pos[i] = 0;
  endtask

  function automatic logic pending();
    pending = 1'b0;
    for (int i = 0; i < 3; i++) if (s_pos[i] < s_len[i]) pending = 1'b1;
  endfunction

  // One clock: note handshakes due at the coming rising edge, then advance sources.
  task automatic step();
    logic [2:0] fire;
    #1;
    fire = req_valid & req_ready;
    if (tx_valid && tx_ready) out_q.push_back(tx_data);
    if (grant != 3'b000 && last_grant == 3'b000) grant_q.push_back(grant);
    last_grant = grant;
    @(negedge clk);
    for (int i = 0; i < 3; i++) if (fire[i]) s_pos[i]++;
    drive();
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_len[i] = 0;
      s_pos[i] = 0;
    end
    drive();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    out_q.delete();
    grant_q.delete();
    last_grant = 3'b000;
  endtask

  task automatic run_until_idle(input string tag, input int max);
    int k;
    k = 0;
    while ((pending() || busy) && k < max) begin
      step();
      k++;
    end
    chk({tag, "_done"}, {31'd0, pending() | busy}, 32'd0);
  endtask

  task automatic chk_stream(input string tag, input int n, input logic [63:0] exp);
    chk({tag, "_len"}, out_q.size(), n);
    for (int k = 0; k < n; k++)
      chk($sformatf("%s[%0d]", tag, k), (k < out_q.size()) ? {24'd0, out_q[k]} : 32'hFFFF_FFFF,
          {24'd0, exp[8*k +: 8]});
  endtask

  task automatic chk_grants(input string tag, input int n, input logic [11:0] exp);
    chk({tag, "_len"}, grant_q.size(), n);
    for (int k = 0; k < n; k++)
      chk($sformatf("%s[%0d]", tag, k), (k < grant_q.size()) ? {29'd0, grant_q[k]} : 32'hFFFF_FFFF,
          {29'd0, exp[3*k +: 3]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b1; rst = 1'b0;
    last_grant = 3'b000;
    do_reset();

    // Reset state
    chk("rst_grant", grant, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_abort", abort, 0);

    // Basic packet AA BB CC from requester 0
    load(0, 3, 64'h0000_0000_00CC_BBAA, 8'b100);
    drive();
    step();
    chk("basic_grant", grant, 3'b001);
    chk("basic_ready", req_ready, 3'b001);
    chk("basic_txv0", tx_valid, 0);
    step();
    chk("basic_txv1", tx_valid, 1);
    chk("basic_aa", tx_data, 8'hAA);
    step();
    chk("basic_bb", tx_data, 8'hBB);
    step();
    chk("basic_cc", tx_data, 8'hCC);
    chk("basic_grant_end", grant, 3'b000);
    step();
    chk("basic_busy_end", busy, 0);
    chk("basic_grant_end2", grant, 3'b000);
    chk("basic_txv_end", tx_valid, 0);
    chk_stream("basic_out", 3, 64'h0000_0000_00CC_BBAA);

    // Round robin: all three request together from rr_ptr=0
    do_reset();
    load(0, 2, 64'h1110, 8'b10);
    load(1, 2, 64'h2120, 8'b10);
    load(2, 2, 64'h3130, 8'b10);
    drive();
    run_until_idle("rr", 60);
    chk_stream("rr_out", 6, 64'h0000_3130_2120_1110);
    chk_grants("rr_grant", 3, {3'b100, 3'b010, 3'b001});

    // Backpressure: stall tx_ready for 10 cycles with 42 in the output register
    do_reset();
    load(1, 4, 64'h4443_4241, 8'b1000);
    drive();
    step();
    step();
    step();
    chk("bp_pre", tx_data, 8'h42);
    tx_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("bp_txv%0d", c), tx_valid, 1);
      chk($sformatf("bp_txd%0d", c), tx_data, 8'h42);
      chk($sformatf("bp_rdy%0d", c), req_ready, 0);
    end
    tx_ready = 1'b1;
    run_until_idle("bp", 40);
    chk_stream("bp_out", 4, 64'h4443_4241);

    // Fairness: requester 0 keeps requesting, requester 2 must get in between
    do_reset();
    load(0, 4, 64'h5352_5150, 8'b1010);
    load(2, 2, 64'h7170, 8'b10);
    drive();
    run_until_idle("fair", 60);
    chk_stream("fair_out", 6, 64'h0000_5352_7170_5150);
    chk_grants("fair_grant", 3, {3'b001, 3'b100, 3'b001});

    // Stall: requester 1 sends one non-last byte then drops valid
    do_reset();
    load(1, 1, 64'h60, 8'b0);
    drive();
    step();
    chk("to_grant", grant, 3'b010);
    step();
`ifdef TX_ARB_TIMEOUT_EN
    repeat (8) step();
    chk("to_abort_pre", abort, 0);
    chk("to_grant_pre", grant, 3'b010);
    step();
    chk("to_abort", abort, 1);
    chk("to_grant_drop", grant, 3'b000);
    step();
    chk("to_abort_post", abort, 0);
`else
    repeat (100) step();
    chk("hold_grant", grant, 3'b010);
    chk("hold_abort", abort, 0);
    chk("hold_busy", busy, 1);
`endif
    chk_stream("to_out", 1, 64'h60);

    // Async reset mid-packet, then arbitration restarts from index 0
    do_reset();
    load(0, 1, 64'h80, 8'b1);
    drive();
    run_until_idle("rm_pre", 20);
    load(1, 3, 64'h92_9190, 8'b100);
    drive();
    step();
    chk("rm_grant", grant, 3'b010);
    step();
    chk("rm_txv", tx_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rm_grant0", grant, 0);
    chk("rm_ready0", req_ready, 0);
    chk("rm_txv0", tx_valid, 0);
    chk("rm_txd0", tx_data, 0);
    chk("rm_busy0", busy, 0);
    chk("rm_abort0", abort, 0);
    do_reset();
    load(0, 1, 64'hA0, 8'b1);
    load(1, 1, 64'hB0, 8'b1);
    drive();
    run_until_idle("rm_post", 20);
    chk_grants("rm_order", 2, {6'd0, 3'b010, 3'b001});
    chk_stream("rm_out", 2, 64'hB0A0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
